sti_load_ctrl: RTL
==================

// Module: sti_load_ctrl
// PURPOSE
//  Command-buffered sequencer driving the STI parallel-load port. Host pushes
//  word commands into an internal FIFO; controller issues one load per word,
//  waits for the serial burst (so_valid) to complete, then issues the next.
//  Issues pi_end after a host end request once all queued words are sent.
// PARAMETERS
//  DEPTH    4    FIFO entries (power of 2, >=2)
//  GAP_CYC  1    idle cycles between so_valid fall and next load (0..15)
//  TMO_CYC  64   cycles from load to so_valid rise before timeout error
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  cmd_wr     in   1   push cmd_data (ignored when cmd_full or done)
//  cmd_data   in   21  {pi_low,pi_msb,pi_fill,pi_length[1:0],pi_data[15:0]}
//  end_req    in   1   one-cycle pulse: end after FIFO drains
//  so_valid   in   1   STI serial-valid, monitored for burst completion
//  cmd_full   out  1   FIFO holds DEPTH entries
//  cmd_empty  out  1   FIFO holds 0 entries
//  load       out  1   one-cycle load strobe to STI
//  pi_data    out  16  word to STI, held until next load
//  pi_length  out  2   00=8b 01=16b 10=24b 11=32b
//  pi_fill, pi_msb, pi_low  out 1 each  STI mode bits, held with pi_data
//  pi_end     out  1   one-cycle end strobe to STI
//  busy       out  1   state != IDLE && state != DONE
//  done       out  1   sticky after pi_end issued
//  err        out  1   sticky: timeout (and bit-count error if enabled)
// BEHAVIOUR
//  Reset: all outputs 0, cmd_empty=1, FIFO pointers 0, state IDLE, end flag 0.
//  FIFO: 1-cycle write; push+pop same cycle when full is legal (count holds).
//   Write while full or done dropped, no state change.
//  FSM:
//   IDLE : FIFO non-empty -> pop head, load=1 next cycle, pi_* = head -> LOAD.
//          else end flag set -> pi_end=1 one cycle -> DONE.
//   LOAD : wait so_valid=1 -> XMIT; TMO_CYC cycles without it -> err=1 -> IDLE.
//   XMIT : count so_valid-high cycles; so_valid=0 -> GAP (GAP_CYC=0: IDLE).
//   GAP  : count GAP_CYC cycles -> IDLE.
//   DONE : terminal until reset; load/pi_end stay 0; cmd_wr ignored.
//  Load latency: word written to empty FIFO in IDLE -> load asserted 2 cycles
//   after cmd_wr edge. pi_* valid in same cycle as load, unchanged to next load.
//  end_req latched into end flag in any state except DONE; words already
//   queued (incl. same-cycle cmd_wr) are sent before pi_end.
//  Expected bits N = 8*(pi_length+1); counter 6 bits, saturates at 63.
//  Timeout does not drop later words; FSM resumes with next FIFO entry.
//  Async reset mid-burst: immediate return to reset values; FIFO flushed.
// CONFIGURATION
//  STI_BITCHK_EN defined: on XMIT exit, counted so_valid cycles != N sets err
//   (sticky); sequencing unchanged.
//  Not defined: count logic absent; err reflects timeout only.
// TESTING
//  1 push 0xA5C3 len=01 msb=1; model so_valid high 16 cyc -> one load, pi_data
//    0xA5C3, next load >= GAP_CYC+1 cycles after so_valid fall, err=0.
//  2 push 4 words DEPTH=4 -> cmd_full=1; 5th push dropped; exactly 4 loads in
//    FIFO order, cmd_empty=1 after 4th pop.
//  3 push 2 words then end_req same cycle as 2nd -> 2 loads then pi_end pulse,
//    done=1, busy=0; later cmd_wr ignored, no further load.
//  4 load with so_valid never rising -> err=1 at TMO_CYC=64 cycles; queued next
//    word still loaded.
//  5 STI_BITCHK_EN, len=00, so_valid high 7 cyc -> err=1; 8 cyc -> err stays 0.
//  6 reset=0 during XMIT with 3 queued -> outputs 0, cmd_empty=1, no load after
//    release until new cmd_wr.

Source files
------------

// File: rtl/sti_load_ctrl.sv
// sti_load_ctrl: FIFO-buffered sequencer issuing STI parallel loads, one per queued word, then pi_end.
// Define STI_BITCHK_EN to flag bursts whose so_valid length differs from the word's bit count.
module sti_load_ctrl #(
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 1,
  parameter int TMO_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_wr,
  input  logic [20:0] cmd_data,
  input  logic        end_req,
  input  logic        so_valid,
  output logic        cmd_full,
  output logic        cmd_empty,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TMO_CYC + 16);
  typedef enum logic [2:0] {IDLE, LOAD, XMIT, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [20:0] mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] fill_q, fill_d;
  logic [20:0] pi_q, pi_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic load_q, load_d, pend_q, pend_d, end_q, end_d, err_q, err_d;
  logic push, pop;
`ifdef STI_BITCHK_EN
  logic [5:0] bits_q, bits_d;
  logic [5:0] bits_n;
  assign bits_n = {1'b0, pi_q[17:16], 3'b000} + 6'd8;
`endif
  assign cmd_full  = fill_q == (AW+1)'(DEPTH);
  assign cmd_empty = fill_q == '0;
  assign pop       = state_q == IDLE && !cmd_empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign push      = cmd_wr && state_q != DONE && (!cmd_full || pop);
  assign load      = load_q;
  assign pi_end    = pend_q;
  assign err       = err_q;
  assign done      = state_q == DONE;
  assign busy      = state_q != IDLE && state_q != DONE;
  assign {pi_low, pi_msb, pi_fill, pi_length, pi_data} = pi_q;
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pi_d    = pi_q;
    load_d  = 1'b0;
    pend_d  = 1'b0;
    err_d   = err_q;
    end_d   = end_q | (end_req && state_q != DONE);
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    fill_d  = fill_q + (AW+1)'(push) - (AW+1)'(pop);
`ifdef STI_BITCHK_EN
    bits_d  = bits_q;
`endif
    case (state_q)
      IDLE: begin
        if (pop) begin
          pi_d    = mem[rd_q];
          load_d  = 1'b1;
          tmr_d   = '0;
          state_d = LOAD;
        end else if (end_q) begin
          pend_d  = 1'b1;
          state_d = DONE;
        end
      end
      LOAD: begin
        if (so_valid) begin
          state_d = XMIT;
`ifdef STI_BITCHK_EN
          bits_d  = 6'd1;
`endif
        end else if (tmr_q == CW'(TMO_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      XMIT: begin
        if (so_valid) begin
`ifdef STI_BITCHK_EN
          bits_d = (bits_q == 6'd63) ? bits_q : bits_q + 6'd1;
`endif
        end else begin
          state_d = (GAP_CYC == 0) ? IDLE : GAP;
          tmr_d   = '0;
`ifdef STI_BITCHK_EN
          err_d   = err_q | (bits_q != bits_n);
`endif
        end
      end
      GAP: begin
        state_d = (tmr_q == CW'(GAP_CYC - 1)) ? IDLE : GAP;
        tmr_d   = tmr_q + 1'b1;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= cmd_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      fill_q  <= '0;
      pi_q    <= '0;
      tmr_q   <= '0;
      load_q  <= 1'b0;
      pend_q  <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef STI_BITCHK_EN
      bits_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fill_q  <= fill_d;
      pi_q    <= pi_d;
      tmr_q   <= tmr_d;
      load_q  <= load_d;
      pend_q  <= pend_d;
      end_q   <= end_d;
      err_q   <= err_d;
`ifdef STI_BITCHK_EN
      bits_q  <= bits_d;
`endif
    end
  end
endmodule
